pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Central hazard and sequencing controller for the 4 pipeline registers of the 5-stage core: IF/ID=0, ID/EX=1, EX/MEM=2, MEM/WB=3.
- Drives each register's hold_en and set_default pins, plus the PC hold and redirect strobes.
- Arbitrates between memory stall, trap, multicycle-EX busy, taken branch and load-use hazards.
- Sequences fetch-refill after redirects and the debug halt drain.

Parameters:
REFILL_CYC, 1, cycles IF/ID is forced to default after a redirect (fetch latency); legal range 1..7
DRAIN_CYC, 4, advancing cycles needed to empty the pipeline before reporting halted
CNT_W, 32, width of the stall performance counter

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous, active-low
mem_stall_i  in  1  data bus not ready for the instruction in MEM
trap_i  in  1  exception/interrupt taken by the instruction in MEM
ex_busy_i  in  1  multicycle unit (mul/div) in EX not done
branch_taken_i  in  1  branch/jump in EX resolved taken
load_use_i  in  1  ID instruction depends on a load in EX
halt_req_i  in  1  debug halt request (level)
resume_i  in  1  debug resume pulse
hold_o  out  4  hold_en per pipe register, bit n = register n
flush_o  out  4  set_default per pipe register
pc_hold_o  out  1  freeze PC/fetch
redirect_o  out  1  PC loads trap vector (trap) or branch target (branch) this cycle
halted_o  out  1  pipeline empty and halted (registered)
stall_cnt_o  out  CNT_W  cycles with pc_hold_o=1 outside HALTED (registered)

Behaviour:
- hold_o, flush_o, pc_hold_o and redirect_o are combinational from inputs and registered state. State, counters and halted_o are registered.
- While rst_n=0: flush_o=4'b1111, hold_o=0, pc_hold_o=1, redirect_o=0, halted_o=0, stall_cnt_o=0, state=RUN, refill counter=0.
- Event priority is highest first; only the highest active event applies:
  - mem_stall_i: hold=0111, flush=1000, pc_hold=1. No redirect, even if trap_i/branch_taken_i are also high; they are re-presented next cycle.
  - trap_i: flush=1111, hold=0, redirect=1. Refill counter loaded with REFILL_CYC.
  - ex_busy_i: hold=0011, flush=0100, pc_hold=1. A branch in EX is deferred.
  - branch_taken_i: flush=0011, redirect=1. Refill counter loaded with REFILL_CYC.
  - load_use_i: hold=0001, flush=0010, pc_hold=1.
  - none: hold=0, flush=0, pc_hold=0.
- Refill:
  - While the refill counter is nonzero, flush[0] is additionally forced to 1 and hold[0] is forced to 0.
  - The counter decrements each cycle without mem_stall_i. A new redirect reloads it.
- Flush dominates hold for the same register; pc_hold is never set in a cycle with redirect_o=1.
- State machine RUN / DRAIN / HALTED:
  - RUN -> DRAIN when halt_req_i=1 and no redirect occurs this cycle. The drain counter is loaded with DRAIN_CYC.
  - DRAIN: pc_hold=1 and flush[0]=1 on top of the event table. The counter decrements only in cycles with mem_stall_i=0 and ex_busy_i=0. A redirect in DRAIN reloads it with DRAIN_CYC.
  - DRAIN -> HALTED when the counter reaches 0 (halted_o=1 the next cycle). DRAIN -> RUN if halt_req_i drops.
  - HALTED: pc_hold=1, flush[0]=1, hold=0, halted_o=1.
  - HALTED -> RUN on resume_i (halted_o=0 the next cycle). resume_i is ignored in other states.
- stall_cnt_o increments by 1 in each cycle with pc_hold_o=1 in RUN or DRAIN; it wraps modulo 2^CNT_W.
- Reset asserted mid-drain or mid-refill returns to RUN with all counters cleared.

Decomposition:
- Shared pipeline package holds:
  - Stage index constants: STG_IFID=0, STG_IDEX=1, STG_EXMEM=2, STG_MEMWB=3.
  - The 2-bit state encoding: RUN=0, DRAIN=1, HALTED=2.
- One natural sub-module, pipe_ctrl_cnt: a loadable down-counter with enable and zero flag, instantiated for both the refill and drain counters.

Test Plan:
- Idle RUN, all inputs 0 -> hold=0000, flush=0000, pc_hold=0; stall_cnt_o unchanged for 10 cycles.
- load_use_i for 1 cycle -> hold=0001, flush=0010, pc_hold=1, stall_cnt_o +1; 3 back-to-back cycles -> +3.
- branch_taken_i with REFILL_CYC=2 -> redirect=1, flush=0011; next 2 cycles flush[0]=1; third cycle flush=0000.
- mem_stall_i and trap_i together for 3 cycles, then mem_stall_i drops:
  - Stall cycles: hold=0111, flush=1000, redirect=0.
  - 4th cycle: flush=1111, redirect=1.
- halt_req_i high with ex_busy_i high for 2 cycles:
  - halted_o rises after DRAIN_CYC+2=6 cycles.
  - resume_i pulse -> halted_o=0 the next cycle, pc_hold=0.
- rst_n pulled low in DRAIN -> flush_o=1111 immediately (asynchronous), state RUN, halted_o=0, stall_cnt_o=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared definitions for the pipeline controller: stage indices
//               of the four pipeline registers and the controller state codes.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

   // Pipeline register indices (bit positions in hold/flush vectors)
   localparam int STG_IFID  = 0;
   localparam int STG_IDEX  = 1;
   localparam int STG_EXMEM = 2;
   localparam int STG_MEMWB = 3;

   // Controller sequencing states
   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_cnt.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_cnt
// Description : Loadable down-counter with decrement enable and zero flag.
//               Load has priority over decrement; the count saturates at 0.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_cnt #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: reload wins, otherwise step down until zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Count register, cleared by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Hazard and sequencing controller for the four pipeline
//               registers of the 5-stage core. Prioritises stall, trap,
//               multicycle busy, branch and load-use events, forces fetch
//               refill after redirects and sequences the debug halt drain.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REFILL_CYC = 1,
   parameter int DRAIN_CYC  = 4,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mem_stall_i,
   input  logic             trap_i,
   input  logic             ex_busy_i,
   input  logic             branch_taken_i,
   input  logic             load_use_i,
   input  logic             halt_req_i,
   input  logic             resume_i,
   output logic [3:0]       hold_o,
   output logic [3:0]       flush_o,
   output logic             pc_hold_o,
   output logic             redirect_o,
   output logic             halted_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   localparam int DRAIN_W = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

   state_e           state_q, state_d;
   logic             halted_q, halted_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic [3:0] hold;
   logic [3:0] flush;
   logic       pc_hold;
   logic       redirect;
   logic       refill_zero;
   logic       drain_zero;
   logic       drain_load;
   logic       drain_en;

   // Event arbitration plus refill/drain/halt overlays on the register controls
   always_comb begin
      hold     = '0;
      flush    = '0;
      pc_hold  = 1'b0;
      redirect = 1'b0;
      if (mem_stall_i) begin
         // MEM instruction waits; trap/branch are re-presented next cycle
         hold[STG_IFID]   = 1'b1;
         hold[STG_IDEX]   = 1'b1;
         hold[STG_EXMEM]  = 1'b1;
         flush[STG_MEMWB] = 1'b1;
         pc_hold          = 1'b1;
      end else if (trap_i) begin
         flush    = 4'b1111;
         redirect = 1'b1;
      end else if (ex_busy_i) begin
         hold[STG_IFID]   = 1'b1;
         hold[STG_IDEX]   = 1'b1;
         flush[STG_EXMEM] = 1'b1;
         pc_hold          = 1'b1;
      end else if (branch_taken_i) begin
         flush[STG_IFID]  = 1'b1;
         flush[STG_IDEX]  = 1'b1;
         redirect         = 1'b1;
      end else if (load_use_i) begin
         hold[STG_IFID]   = 1'b1;
         flush[STG_IDEX]  = 1'b1;
         pc_hold          = 1'b1;
      end
      // Fetch has not produced a valid instruction yet after a redirect
      if (!refill_zero) begin
         flush[STG_IFID] = 1'b1;
         hold[STG_IFID]  = 1'b0;
      end
      if (state_q == ST_DRAIN) begin
         pc_hold         = 1'b1;
         flush[STG_IFID] = 1'b1;
      end
      if (state_q == ST_HALTED) begin
         hold     = '0;
         flush    = 4'b0001;
         pc_hold  = 1'b1;
         redirect = 1'b0;
      end
      hold = hold & ~flush;
      if (redirect) begin
         pc_hold = 1'b0;
      end
   end

   // Next-state logic for RUN/DRAIN/HALTED and drain counter control
   always_comb begin
      state_d    = state_q;
      drain_load = 1'b0;
      drain_en   = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (halt_req_i && !redirect) begin
               state_d    = ST_DRAIN;
               drain_load = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (!halt_req_i) begin
               state_d = ST_RUN;
            end else if (redirect) begin
               drain_load = 1'b1;
            end else if (drain_zero) begin
               state_d = ST_HALTED;
            end else begin
               drain_en = !mem_stall_i && !ex_busy_i;
            end
         end
         ST_HALTED: begin
            if (resume_i) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Halt status and stall performance counter next values
   always_comb begin
      halted_d    = (state_d == ST_HALTED);
      stall_cnt_d = stall_cnt_q;
      if (pc_hold && (state_q != ST_HALTED)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // State, halt flag and stall counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         halted_q    <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         halted_q    <= halted_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   pipe_ctrl_cnt #(.W(3)) u_refill_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (redirect),
      .load_val_i (3'(REFILL_CYC)),
      .en_i       (!mem_stall_i),
      .zero_o     (refill_zero)
   );

   pipe_ctrl_cnt #(.W(DRAIN_W)) u_drain_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (drain_load),
      .load_val_i (DRAIN_W'(DRAIN_CYC)),
      .en_i       (drain_en),
      .zero_o     (drain_zero)
   );

   // While reset is held the pipeline is forced to its default contents
   assign hold_o      = rst_n ? hold     : 4'b0000;
   assign flush_o     = rst_n ? flush    : 4'b1111;
   assign pc_hold_o   = rst_n ? pc_hold  : 1'b1;
   assign redirect_o  = rst_n ? redirect : 1'b0;
   assign halted_o    = halted_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule
`default_nettype wire
